// File: rtl/cv32e40p_obi_tb_pkg.sv
// Shared types and helpers for the OBI memory responder.
//   obi_resp_entry_t : one queued response (read data plus cycles since grant)
//   OBI_MAX_LATENCY  : saturation value of the entry age counter
//   lfsr_next()      : one step of the 32-bit Galois LFSR used for grant stalls
package cv32e40p_obi_tb_pkg;

  localparam int unsigned OBI_MAX_LATENCY = 15;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  age;
  } obi_resp_entry_t;

  // Right-shifting Galois LFSR, taps for x^32 + x^22 + x^2 + x^1 + 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state);
    return {1'b0, state[31:1]} ^ (state[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/cv32e40p_obi_resp_fifo.sv
// In-order response queue for the OBI memory responder.
//   clk_i, rst_i   : clock, synchronous active-high reset (empties the queue)
//   push_i         : enqueue push_entry_i
//   pop_i          : dequeue the head (caller guarantees head_valid_o)
//   head_o         : oldest entry, head_valid_o when it is occupied
//   count_o        : number of occupied entries
// Every occupied entry ages by one per cycle, saturating at OBI_MAX_LATENCY.
module cv32e40p_obi_resp_fifo
  import cv32e40p_obi_tb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  obi_resp_entry_t push_entry_i,
  input  logic            pop_i,
  output obi_resp_entry_t head_o,
  output logic            head_valid_o,
  output logic [2:0]      count_o
);

  localparam int unsigned    PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [3:0]     AgeMax  = 4'(OBI_MAX_LATENCY);

  obi_resp_entry_t  entries_q [Depth];
  logic [Depth-1:0] valid_q, valid_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pop_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (PtrW'(i) == rd_ptr_q) valid_d[i] = 1'b0;
      end
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    // The grant logic never pushes into a full queue, so the write slot is free.
    if (push_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (PtrW'(i) == wr_ptr_q) valid_d[i] = 1'b1;
      end
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: only slots flagged in valid_q are ever observed.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < Depth; i++) begin
      if (push_i && (PtrW'(i) == wr_ptr_q)) begin
        entries_q[i] <= push_entry_i;
      end else if (valid_q[i] && (entries_q[i].age != AgeMax)) begin
        entries_q[i].age <= entries_q[i].age + 4'd1;
      end
    end
  end

  always_comb begin
    head_o       = entries_q[0];
    head_valid_o = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (PtrW'(i) == rd_ptr_q) begin
        head_o       = entries_q[i];
        head_valid_o = valid_q[i];
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI memory-side responder used by the core testbench (one per port).
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_i / gnt_o         : OBI address phase handshake (gnt_o combinational)
//   addr_i, we_i, be_i,
//   wdata_i               : transaction attributes, sampled in the grant cycle
//   rvalid_o, rdata_o     : in-order responses, rdata_o is 0 for writes
//   outstanding_o         : granted-but-unanswered transaction count
// Writes commit at the grant edge; reads sample the array in the grant cycle.
// The word array is not reset, so contents survive rst_i.
module cv32e40p_obi_mem_responder
  import cv32e40p_obi_tb_pkg::*;
#(
  parameter int unsigned MEM_WORDS       = 16384,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned GNT_STALL_EN    = 0,
  parameter logic [31:0] LFSR_SEED       = 32'h1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [2:0]  outstanding_o
);

  localparam int unsigned IdxW   = $clog2(MEM_WORDS);
  localparam logic [2:0]  MaxOut = 3'(MAX_OUTSTANDING);
  localparam logic [3:0]  LatM1  = 4'(RESP_LATENCY - 1);

  logic [31:0]     mem_q [MEM_WORDS];
  logic [IdxW-1:0] idx;
  logic [31:0]     lfsr_q;
  logic [31:0]     rdata_q;
  logic            stall;
  logic            grant;
  logic            pop;
  obi_resp_entry_t push_entry;
  obi_resp_entry_t head;
  logic            head_valid;
  logic [2:0]      count;
  logic            unused_addr;

  // Upper address bits wrap the array; byte offset is ignored.
  assign idx         = addr_i[IdxW+1:2];
  assign unused_addr = ^{addr_i[31:IdxW+2], addr_i[1:0]};

  assign stall = (GNT_STALL_EN != 0) && lfsr_q[0];

  // Only the registered count gates the grant; a same-cycle pop frees nothing.
  assign grant = req_i && !rst_i && (count < MaxOut) && !stall;
  assign gnt_o = grant;

  assign push_entry.rdata = we_i ? 32'h0 : mem_q[idx];
  assign push_entry.age   = 4'd0;

  // Decoded purely from queue flops: an entry pushed at the grant edge has age 0
  // in the following cycle, so age == RESP_LATENCY-1 lands RESP_LATENCY cycles
  // after the grant.
  assign pop = head_valid && (head.age >= LatM1) && !rst_i;

  cv32e40p_obi_resp_fifo #(
    .Depth(MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (grant),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .head_valid_o (head_valid),
    .count_o      (count)
  );

  always_ff @(posedge clk_i) begin
    if (grant && we_i) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be_i[k]) mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q  <= LFSR_SEED;
      rdata_q <= 32'h0;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
      if (pop) rdata_q <= head.rdata;
    end
  end

  assign rvalid_o      = pop;
  assign rdata_o       = pop ? head.rdata : rdata_q;
  assign outstanding_o = count;

`ifdef CV32E40P_ASSERT_ON
  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    count <= MaxOut);
  a_rvalid_nonempty: assert property (@(posedge clk_i) disable iff (rst_i)
    rvalid_o |-> (count != 3'd0));
  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (req_i && !gnt_o) |=> (req_i && $stable(addr_i) && $stable(we_i) &&
                           $stable(be_i) && $stable(wdata_i)));
`endif

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
module tb_cv32e40p_obi_mem_responder;

  logic        clk = 1'b0;
  logic        rst    [3];
  logic        req    [3];
  logic        gnt    [3];
  logic [31:0] addr   [3];
  logic        we     [3];
  logic [3:0]  be     [3];
  logic [31:0] wdata  [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];
  logic [2:0]  outst  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // u_a: latency 1; u_b: latency 4; u_c: latency 3. All allow 2 outstanding.
  cv32e40p_obi_mem_responder #(
    .MEM_WORDS(16384), .MAX_OUTSTANDING(2), .RESP_LATENCY(1), .GNT_STALL_EN(0), .LFSR_SEED(32'h1)
  ) u_a (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]), .we_i(we[0]),
    .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
    .outstanding_o(outst[0])
  );

  cv32e40p_obi_mem_responder #(
    .MEM_WORDS(16384), .MAX_OUTSTANDING(2), .RESP_LATENCY(4), .GNT_STALL_EN(0), .LFSR_SEED(32'h1)
  ) u_b (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]), .we_i(we[1]),
    .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
    .outstanding_o(outst[1])
  );

  cv32e40p_obi_mem_responder #(
    .MEM_WORDS(16384), .MAX_OUTSTANDING(2), .RESP_LATENCY(3), .GNT_STALL_EN(0), .LFSR_SEED(32'h1)
  ) u_c (
    .clk_i(clk), .rst_i(rst[2]), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]), .we_i(we[2]),
    .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]),
    .outstanding_o(outst[2])
  );

  // One isolated transaction on instance u. gwait = cycles without grant,
  // lat = cycles from grant cycle to rvalid, single = rvalid dropped afterwards.
  task automatic xfer(input int u, input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, output int gwait, output int lat,
                      output logic [31:0] rd, output logic single);
    gwait = 0;
    lat   = 1;
    @(posedge clk); #1;
    req[u] = 1'b1; we[u] = w; be[u] = b; addr[u] = a; wdata[u] = d;
    @(negedge clk);
    while (!gnt[u] && gwait < 20) begin
      gwait++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    req[u] = 1'b0; we[u] = 1'b0;
    @(negedge clk);
    while (!rvalid[u] && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    rd = rdata[u];
    @(negedge clk);
    single = !rvalid[u];
  endtask

  task automatic test_reset();
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1; req[u] = 1'b1; we[u] = 1'b0; be[u] = 4'h0; addr[u] = 32'h0; wdata[u] = 32'h0;
    end
    @(posedge clk); #1;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (gnt[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_gnt[%0d]: got %b expected 0", u, gnt[u]);
      end
    end
    @(posedge clk); #1;
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b0; req[u] = 1'b0;
    end
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (rvalid[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_rvalid[%0d]: got %b expected 0", u, rvalid[u]);
      end
      checks++;
      if (rdata[u] !== 32'h0) begin
        errors++;
        $display("FAIL reset_rdata[%0d]: got %h expected 0", u, rdata[u]);
      end
      checks++;
      if (outst[u] !== 3'd0) begin
        errors++;
        $display("FAIL reset_outstanding[%0d]: got %0d expected 0", u, outst[u]);
      end
    end
  endtask

  task automatic test_write_read();
    int gw, lat;
    logic [31:0] rd;
    logic single;
    xfer(0, 1'b1, 4'hF, 32'h100, 32'hCAFE_BABE, gw, lat, rd, single);
    checks++;
    if (gw !== 0 || lat !== 1 || single !== 1'b1) begin
      errors++;
      $display("FAIL wr_timing: gwait=%0d lat=%0d single=%b expected 0 1 1", gw, lat, single);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL wr_rdata: got %h expected 00000000", rd);
    end
    xfer(0, 1'b0, 4'hF, 32'h100, 32'h0, gw, lat, rd, single);
    checks++;
    if (gw !== 0 || lat !== 1 || single !== 1'b1) begin
      errors++;
      $display("FAIL rd_timing: gwait=%0d lat=%0d single=%b expected 0 1 1", gw, lat, single);
    end
    checks++;
    if (rd !== 32'hCAFE_BABE) begin
      errors++;
      $display("FAIL rd_data: got %h expected cafebabe", rd);
    end
  endtask

  task automatic test_byte_enables();
    int gw, lat;
    logic [31:0] rd;
    logic single;
    xfer(0, 1'b1, 4'hF, 32'h20, 32'h1122_3344, gw, lat, rd, single);
    xfer(0, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, gw, lat, rd, single);
    xfer(0, 1'b0, 4'hF, 32'h20, 32'h0, gw, lat, rd, single);
    checks++;
    if (rd !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL be_merge: got %h expected 11bb33dd", rd);
    end
    // Empty byte mask: still answered, memory untouched.
    xfer(0, 1'b1, 4'h0, 32'h20, 32'hFFFF_FFFF, gw, lat, rd, single);
    checks++;
    if (lat !== 1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL be_zero_resp: lat=%0d rdata=%h expected 1 00000000", lat, rd);
    end
    xfer(0, 1'b0, 4'hF, 32'h20, 32'h0, gw, lat, rd, single);
    checks++;
    if (rd !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL be_zero_mem: got %h expected 11bb33dd", rd);
    end
  endtask

  task automatic test_wrap();
    int gw, lat;
    logic [31:0] rd;
    logic single;
    xfer(0, 1'b1, 4'hF, 32'h0001_0004, 32'h5A5A_5A5A, gw, lat, rd, single);
    xfer(0, 1'b0, 4'hF, 32'h0000_0004, 32'h0, gw, lat, rd, single);
    checks++;
    if (rd !== 32'h5A5A_5A5A) begin
      errors++;
      $display("FAIL wrap: got %h expected 5a5a5a5a", rd);
    end
    xfer(0, 1'b0, 4'hF, 32'h0000_0007, 32'h0, gw, lat, rd, single);
    checks++;
    if (rd !== 32'h5A5A_5A5A) begin
      errors++;
      $display("FAIL byte_offset_ignored: got %h expected 5a5a5a5a", rd);
    end
  endtask

  task automatic test_back_pressure();
    int gw, lat, nreq;
    logic [31:0] rd;
    logic single;
    logic [2:0] maxout;
    int gcyc[$];
    int rcyc[$];
    logic [31:0] rdat[$];
    int gexp[4] = '{0, 1, 5, 6};
    int rexp[4] = '{4, 5, 9, 10};
    for (int i = 0; i < 4; i++) begin
      xfer(1, 1'b1, 4'hF, 32'(i * 4), 32'hB0B0_0000 | 32'(i), gw, lat, rd, single);
    end
    nreq   = 0;
    maxout = 3'd0;
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (gnt[1]) begin
        gcyc.push_back(c);
        nreq++;
      end
      if (rvalid[1]) begin
        rcyc.push_back(c);
        rdat.push_back(rdata[1]);
      end
      if (outst[1] > maxout) maxout = outst[1];
      @(posedge clk); #1;
      if (nreq == 4) req[1] = 1'b0;
      else addr[1] = 32'(nreq * 4);
    end
    checks++;
    if (gcyc.size() !== 4 || rcyc.size() !== 4) begin
      errors++;
      $display("FAIL bp_counts: grants=%0d rvalids=%0d expected 4 4", gcyc.size(), rcyc.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < gcyc.size()) begin
        checks++;
        if (gcyc[i] !== gexp[i]) begin
          errors++;
          $display("FAIL bp_grant_cycle[%0d]: got %0d expected %0d", i, gcyc[i], gexp[i]);
        end
      end
      if (i < rcyc.size()) begin
        checks++;
        if (rcyc[i] !== rexp[i] || rdat[i] !== (32'hB0B0_0000 | 32'(i))) begin
          errors++;
          $display("FAIL bp_resp[%0d]: cycle=%0d data=%h expected %0d %h", i, rcyc[i], rdat[i],
                   rexp[i], 32'hB0B0_0000 | 32'(i));
        end
      end
    end
    checks++;
    if (maxout !== 3'd2) begin
      errors++;
      $display("FAIL bp_peak_outstanding: got %0d expected 2", maxout);
    end
  endtask

  task automatic test_latency();
    int gw, lat;
    logic [31:0] rd;
    logic single;
    xfer(2, 1'b1, 4'hF, 32'h40, 32'h0C0C_0C0C, gw, lat, rd, single);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL lat3_write: got %0d expected 3", lat);
    end
    xfer(2, 1'b0, 4'hF, 32'h40, 32'h0, gw, lat, rd, single);
    checks++;
    if (gw !== 0 || lat !== 3 || single !== 1'b1 || rd !== 32'h0C0C_0C0C) begin
      errors++;
      $display("FAIL lat3_read: gwait=%0d lat=%0d single=%b data=%h expected 0 3 1 0c0c0c0c",
               gw, lat, single, rd);
    end
  endtask

  task automatic test_reset_midflight();
    logic g0, g1;
    int nrv, bad_out, gw, lat;
    logic [31:0] rd;
    logic single;
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
    @(negedge clk);
    g0 = gnt[1];
    @(posedge clk); #1;
    addr[1] = 32'h4;
    @(negedge clk);
    g1 = gnt[1];
    @(posedge clk); #1;
    req[1] = 1'b0; rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    nrv = 0;
    bad_out = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rvalid[1]) nrv++;
      if (outst[1] !== 3'd0) bad_out++;
    end
    checks++;
    if (g0 !== 1'b1 || g1 !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_grants: got %b %b expected 1 1", g0, g1);
    end
    checks++;
    if (nrv !== 0 || bad_out !== 0) begin
      errors++;
      $display("FAIL rst_mid_drop: rvalids=%0d nonzero_outstanding=%0d expected 0 0", nrv, bad_out);
    end
    xfer(1, 1'b0, 4'hF, 32'h8, 32'h0, gw, lat, rd, single);
    checks++;
    if (lat !== 4 || rd !== 32'hB0B0_0002) begin
      errors++;
      $display("FAIL rst_mem_persist: lat=%0d data=%h expected 4 b0b00002", lat, rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_wrap();
    test_back_pressure();
    test_latency();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
